// File: rtl/byte_packer_pkg.sv
// Shared definitions for the byte packer: word size limit, FSM state type
// and the byte-reversal helper used for big-endian presentation.
package fn;

    localparam int MAX_BYTES = 32;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Mirrors the low `size` bytes so byte 0 lands at index size-1; bytes above size stay zero.
    function automatic logic [MAX_BYTES*8-1:0] reverse_bytes(
        input logic [MAX_BYTES*8-1:0] data,
        input logic [7:0]             size
    );
        logic [MAX_BYTES*8-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < int'(size)) begin
                r[(int'(size) - 1 - i)*8 +: 8] = data[i*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into words of up to DATA_BYTES bytes, splitting on
// frame ends, and presents each word with a ready/valid handshake.
module byte_packer
    import fn::*;
#(
    parameter int DATA_BYTES = 32,
    parameter int BIG_ENDIAN = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [MAX_BYTES*8-1:0] out_data,
    output logic [7:0]             out_size,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int         W        = MAX_BYTES * 8;
    localparam logic [5:0] LAST_IDX = 6'(DATA_BYTES - 1);

    state_t       state;
    state_t       state_next;
    logic [5:0]   cnt;
    logic [W-1:0] acc;
    logic [W-1:0] acc_ins;
    logic [7:0]   size_ins;
    logic         accept;
    logic         done;

    assign accept   = in_valid && in_ready;
    assign done     = accept && (in_last || (cnt == LAST_IDX));
    assign size_ins = {2'b00, cnt} + 8'd1;

    always_comb begin
        acc_ins = acc;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (6'(i) == cnt) begin
                acc_ins[i*8 +: 8] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // A retiring word with a completing byte in the same cycle goes straight back to HOLD.
    always_comb begin
        state_next = state;
        if (state == COLLECT) begin
            if (done) begin
                state_next = HOLD;
            end
        end else if (out_ready) begin
            state_next = done ? HOLD : COLLECT;
        end
    end

    always_comb begin
        in_ready  = (state == COLLECT) ? 1'b1 : out_ready;
        out_valid = (state == HOLD);
    end

    // acc and cnt are already cleared while a word is held, so a byte taken
    // during retirement naturally lands at index 0 of the next word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc      <= '0;
            out_data <= '0;
            out_size <= '0;
            out_last <= 1'b0;
        end else if (done) begin
            cnt      <= '0;
            acc      <= '0;
            out_data <= (BIG_ENDIAN != 0) ? reverse_bytes(acc_ins, size_ins) : acc_ins;
            out_size <= size_ins;
            out_last <= in_last;
        end else if (accept) begin
            cnt <= cnt + 6'd1;
            acc <= acc_ins;
        end
    end

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 32, giving the maximum bytes per output word (legal range 1..32).
REQ-002 SHALL have parameter BIG_ENDIAN, default 1; 1 places the first received byte most significant, 0 least significant.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, 8 bits: stream byte.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data/in_last valid.
REQ-007 SHALL have port in_last, input, 1 bit: final byte of frame.
REQ-008 SHALL have port in_ready, output, 1 bit: byte accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port out_data, output, 256 bits: packed word; bytes at index >= out_size are zero.
REQ-010 SHALL have port out_size, output, 8 bits: valid byte count, 1..DATA_BYTES.
REQ-011 SHALL have port out_last, output, 1 bit: word ends a frame.
REQ-012 SHALL have port out_valid, output, 1 bit: out_* valid.
REQ-013 SHALL have port out_ready, input, 1 bit: word consumed when out_valid and out_ready are both high.

Function
REQ-014 SHALL implement two states: COLLECT (assembling) and HOLD (word presented on out_*).
REQ-015 In COLLECT, in_ready SHALL be 1 and out_valid 0; each accepted byte is stored at little-endian index cnt, and cnt increments.
REQ-016 A word SHALL complete on an accepted byte with in_last=1 or with cnt=DATA_BYTES-1; next cycle: state HOLD, out_valid=1, out_size=cnt+1, out_last=in_last of that byte, cnt=0.
REQ-017 Latency SHALL be exactly one cycle from the completing input handshake to out_valid high.
REQ-018 With BIG_ENDIAN=1, out_data SHALL equal the byte-reversal of the little-endian accumulation over out_size bytes (first byte at index out_size-1); with BIG_ENDIAN=0 it SHALL be unmodified.
REQ-019 In HOLD, in_ready SHALL equal out_ready (combinational pass-through); out_* SHALL stay stable while out_ready=0.
REQ-020 In HOLD with out_ready=1: the word retires; an input byte accepted in the same cycle SHALL be stored at index 0 of the next word (cnt=1); next state COLLECT, or HOLD again if that byte completes a word (in_last=1 or DATA_BYTES=1).
REQ-021 The accumulator SHALL clear to zero when a word retires, so stale bytes never appear above out_size.
REQ-022 in_data SHALL be ignored when in_valid=0; in_last with no prior bytes SHALL produce out_size=1.

Reset
REQ-023 While reset_n=0: state=COLLECT, cnt=0, accumulator=0, out_data=0, out_size=0, out_last=0, out_valid=0; in_ready SHALL be 1 the first cycle after release.
REQ-024 Reset asserted mid-word or in HOLD SHALL discard all partial and pending data with no output handshake.

Structure
REQ-025 The byte-reversal function, DATA_BYTES maximum (32) and the state enum typedef SHALL reside in the shared package fn; the module SHALL reuse fn::reverse_bytes.
REQ-026 The block SHALL be a single module with no sub-modules; a separate verification-only model byte_packer_ref is permitted in the bench.

Verification
REQ-027 Bytes 0x11,0x22,0x33 (last on 0x33), BIG_ENDIAN=1, out_ready=1 -> one cycle later out_data[23:0]=0x112233, upper bytes 0, out_size=3, out_last=1.
REQ-028 Same stimulus, BIG_ENDIAN=0 -> out_data[23:0]=0x332211, out_size=3.
REQ-029 40 bytes 0x00..0x27, last on 0x27, DATA_BYTES=32 -> word 1: out_size=32, out_last=0; word 2: out_size=8, out_last=1, BE byte order 0x20..0x27.
REQ-030 out_ready held 0 for 5 cycles in HOLD -> in_ready=0 and out_* stable throughout; on out_ready=1, word retires and a byte offered that cycle lands at index 0 of the next word.
REQ-031 Back-to-back single-byte frames (in_last every byte), out_ready=1 -> one word per cycle, out_size=1, no bubbles.
REQ-032 reset_n pulsed low after 2 of 4 bytes -> out_valid stays 0; subsequent 1-byte frame 0xAA yields out_size=1, out_data[7:0]=0xAA.
